// File: rtl/jk_excitation_driver_if.sv
// Target stream and JK flip-flop bank connection for jk_excitation_driver.
// The master side is the controller plus the flip-flop bank; the slave side is the driver.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] target;
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output target, valid, q,
    input  ready, j, k, busy, done, error
  );

  modport slave (
    input  target, valid, q,
    output ready, j, k, busy, done, error
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// Drives J/K excitation so a JK flip-flop bank reaches a requested state, verifies the
// result through Q feedback, and retries up to MAX_RETRY times before flagging a sticky error.
module jk_excitation_driver #(
  parameter int WIDTH     = 4,
  parameter bit DC_POLICY = 1'b0,
  parameter int MAX_RETRY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  jk_excitation_driver_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [2:0]       retry_q, retry_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             armed_q;
  logic             accept;

  // Don't-care positions of the excitation table are filled with DC_POLICY.
  function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] t);
    excite_j = (~q & t) | (q & {WIDTH{DC_POLICY}});
  endfunction

  function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] t);
    excite_k = (q & ~t) | (~q & {WIDTH{DC_POLICY}});
  endfunction

  // armed_q keeps ready low until the first edge after reset release.
  assign bus.ready = armed_q && (state_q == IDLE);
  assign accept    = bus.valid && bus.ready;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    j_d     = '0;
    k_d     = '0;
    retry_d = retry_q;
    done_d  = 1'b0;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = bus.target;
          error_d = 1'b0;
          retry_d = '0;
          j_d     = excite_j(bus.q, bus.target);
          k_d     = excite_k(bus.q, bus.target);
          state_d = APPLY;
        end
      end
      APPLY: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (bus.q == tgt_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + 3'd1;
          j_d     = excite_j(bus.q, tgt_q);
          k_d     = excite_k(bus.q, tgt_q);
          state_d = APPLY;
        end else begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      retry_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      retry_q <= retry_d;
      done_q  <= done_d;
      error_q <= error_d;
      armed_q <= 1'b1;
    end
  end

  assign bus.j     = j_q;
  assign bus.k     = k_q;
  assign bus.busy  = (state_q == APPLY) || (state_q == CHECK);
  assign bus.done  = done_q;
  assign bus.error = error_q;

endmodule
